fp_add_sub_ctrl: RTL
====================

# fp_add_sub_ctrl

Request/response front end for the single-precision FP adder/subtractor core. Accepts fadd.s/fsub.s requests from the execute stage over a valid/ready handshake. Resolves special operands (NaN, infinity, zero/zero) locally. Otherwise issues a one-cycle `start` pulse to the multicycle core, waits for its `done`, and returns the result with exception flags. It sits directly upstream of the core's control FSM and datapath, and downstream of the FP register read.

## Interface
Parameters:
- `TIMEOUT`, 8: maximum cycles in WAIT before the core is declared hung.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_a`, `req_b` in 32: IEEE-754 binary32 operands.
- `req_sub` in 1: 1 = subtract (b sign inverted).
- `core_start` out 1: one-cycle start pulse to the core.
- `core_a`, `core_b` out 32: registered operands, stable from ISSUE until the next accept.
- `core_done` in 1: core result valid (one-cycle pulse).
- `core_result` in 32: core result, valid while `core_done`.
- `core_underflow` in 1: core underflow indication, valid with `core_done`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_result` out 32: final result.
- `resp_flags` out 5: {NV, DZ, OF, UF, NX}. DZ, OF and NX are always 0 here.
- `resp_timeout` out 1: response was forced by the watchdog.

## Operation
- States:
  - IDLE → CHECK on `req_valid && req_ready`. Operands are latched, and b's sign is flipped if `req_sub`.
  - CHECK → RESP if the operand pair is special; otherwise CHECK → ISSUE.
  - ISSUE → WAIT; `core_start`=1 in ISSUE only.
  - WAIT → RESP on `core_done`, or when the counter reaches TIMEOUT.
  - RESP → IDLE on `resp_ready`.
- Special cases, resolved in CHECK:
  - Either operand is sNaN: result 0x7FC00000, NV=1.
  - Either operand is qNaN: result 0x7FC00000, NV=0.
  - +inf + -inf (after effective sign): 0x7FC00000, NV=1.
  - Exactly one operand is inf: result is that inf, flags 0.
  - Both operands are ±0: result sign = sign_a AND sign_b_eff, magnitude 0.
  - Priority: sNaN > qNaN > inf-inf > single inf > zero/zero.
- Normal path:
  - `resp_result` ← `core_result` captured on `core_done` in WAIT.
  - UF ← `core_underflow`; all other flags 0.
- Watchdog:
  - WAIT counter is 4 bits, cleared on entry to WAIT.
  - On reaching TIMEOUT without `core_done`: result 0x7FC00000, NV=0, `resp_timeout`=1.
- `core_done` is ignored outside WAIT. A stray pulse, e.g. from a core still running after `reset`, has no effect.
- `req_ready` = (state==IDLE).

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`=1.
  - `core_start`=0, `core_a`=`core_b`=0.
  - `resp_valid`=0, `resp_result`=0, `resp_flags`=0, `resp_timeout`=0.
  - counter 0.
- Normal latency, with accept at edge E0:
  - CHECK in cycle 1, `core_start` high in cycle 2.
  - The core asserts `core_done` 6 cycles after the start cycle, in cycle 8.
  - `resp_valid` rises in cycle 9.
- Special latency: `resp_valid` in cycle 2.
- Response hold: `resp_valid`/`resp_result`/`resp_flags` are held stable until `resp_ready`. The next request can be accepted no earlier than the cycle after the response handshake.
- Reset mid-operation returns to IDLE on the next edge and drops `resp_valid`. No partial response is issued.
- `core_start` is never high for two consecutive cycles.

## Structure
- Shared package `fp_pkg`:
  - `CANON_NAN_S` = 32'h7FC00000.
  - State encoding localparams.
  - Flag bit index constants.
- Sub-module `fp_classify`: combinational; given a binary32 operand, outputs is_zero, is_inf, is_qnan, is_snan and sign. Two instances, on a and on b_eff.

## Test plan
- 1.0 (0x3F800000) + 2.0 (0x40000000), core model returns 0x40400000 with `done` 6 cycles after `start` → `resp_valid` in cycle 9, result 0x40400000, flags 0, exactly one `start` pulse.
- sub: a=0x7F800000, b=0x7F800000 → `resp_valid` in cycle 2, result 0x7FC00000, NV=1, `core_start` never asserted.
- a=0x7F800001 (sNaN), b=qNaN 0x7FC00001 → 0x7FC00000, NV=1; then a=1.0, b=0xFF800000 → 0xFF800000, flags 0.
- add: a=0x80000000, b=0x80000000 → 0x80000000; sub with the same operands → 0x00000000.
- Core model never asserts `done` → after TIMEOUT=8 WAIT cycles, result 0x7FC00000 with `resp_timeout`=1; a subsequent late `done` pulse in IDLE is ignored.
- Hold `resp_ready`=0 for 5 cycles → response stable throughout, `req_ready`=0. Assert `reset` during WAIT → IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, state encoding and flag packing for the FP add/sub front end
package fp_pkg;
  localparam logic [31:0] CANON_NAN_S = 32'h7FC00000;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  function automatic logic [4:0] mk_flags(input logic nv, input logic uf);
    logic [4:0] f;
    f = '0;
    f[FLAG_NV] = nv;
    f[FLAG_UF] = uf;
    return f;
  endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: decodes a binary32 operand into zero/inf/qNaN/sNaN/sign (x in; class bits out)
module fp_classify (
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_qnan,
  output logic        is_snan,
  output logic        sign
);
  logic exp_max, man_zero;
  assign exp_max  = &x[30:23];
  assign man_zero = ~|x[22:0];
  assign is_zero  = ~|x[30:0];
  assign is_inf   = exp_max & man_zero;
  assign is_qnan  = exp_max & x[22];
  assign is_snan  = exp_max & ~x[22] & ~man_zero;
  assign sign     = x[31];
endmodule

// File: rtl/fp_add_sub_ctrl.sv
// fp_add_sub_ctrl: req/resp front end for the FP add/sub core (req_* in, core_* to/from core, resp_* out)
module fp_add_sub_ctrl
  import fp_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_sub,
  output logic        core_start,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  input  logic        core_underflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic        resp_timeout
);
  state_t state;
  logic [3:0] cnt;
  logic a_zero, a_inf, a_qnan, a_snan, a_sign;
  logic b_zero, b_inf, b_qnan, b_snan, b_sign;
  logic special, sp_nv, any_nan, inf_inv;
  logic [31:0] sp_result;
  fp_classify u_cls_a (.x(core_a), .is_zero(a_zero), .is_inf(a_inf), .is_qnan(a_qnan), .is_snan(a_snan), .sign(a_sign));
  fp_classify u_cls_b (.x(core_b), .is_zero(b_zero), .is_inf(b_inf), .is_qnan(b_qnan), .is_snan(b_snan), .sign(b_sign));
  assign req_ready = state == S_IDLE;
  // core_b already carries the effective sign, so inf-inf is opposite-signed infinities
  always_comb begin
    any_nan   = a_snan | b_snan | a_qnan | b_qnan;
    inf_inv   = a_inf & b_inf & (a_sign ^ b_sign);
    special   = any_nan | a_inf | b_inf | (a_zero & b_zero);
    sp_nv     = a_snan | b_snan | (~(a_qnan | b_qnan) & inf_inv);
    sp_result = (any_nan | inf_inv) ? CANON_NAN_S :
                a_inf ? core_a :
                b_inf ? core_b :
                {a_sign & b_sign, 31'd0};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      core_start   <= 1'b0;
      core_a       <= '0;
      core_b       <= '0;
      resp_valid   <= 1'b0;
      resp_result  <= '0;
      resp_flags   <= '0;
      resp_timeout <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          core_a <= req_a;
          core_b <= {req_b[31] ^ req_sub, req_b[30:0]};
          state  <= S_CHECK;
        end
        S_CHECK: if (special) begin
          resp_result  <= sp_result;
          resp_flags   <= mk_flags(sp_nv, 1'b0);
          resp_timeout <= 1'b0;
          resp_valid   <= 1'b1;
          state        <= S_RESP;
        end else begin
          core_start <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (core_done) begin
          resp_result  <= core_result;
          resp_flags   <= mk_flags(1'b0, core_underflow);
          resp_timeout <= 1'b0;
          resp_valid   <= 1'b1;
          state        <= S_RESP;
        end else if (cnt == 4'(TIMEOUT - 1)) begin
          resp_result  <= CANON_NAN_S;
          resp_flags   <= '0;
          resp_timeout <= 1'b1;
          resp_valid   <= 1'b1;
          state        <= S_RESP;
        end else begin
          cnt <= cnt + 4'd1;
        end
        S_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
